// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the ALU issue slice: opcodes, funct7 variants,
// funct3 codes that need special decoding, the issue FSM encoding and the control bundle.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  funct3;
    logic        op_sign;
    logic [4:0]  rd;
  } alu_ctrl_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/rv32i_alu_issue_if.sv
// Bundle of decode-side, ALU-side and write-back signals around the issue block.
// master = the issue block; slave = its environment. wb_flags exists only with ALU_ISSUE_FLAGS_EN.
interface rv32i_alu_issue_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            alu_execute;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [2:0]      funct3;
  logic            op_sign;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_negative;
  logic            alu_overflow;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic [2:0]      wb_flags;
`endif
  logic            illegal_instr;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data,
           alu_result, alu_zero, alu_negative, alu_overflow, wb_ready,
    output instr_ready, alu_execute, op_a, op_b, funct3, op_sign,
           wb_valid, wb_rd, wb_data, illegal_instr
`ifdef ALU_ISSUE_FLAGS_EN
    , output wb_flags
`endif
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data,
           alu_result, alu_zero, alu_negative, alu_overflow, wb_ready,
    input  instr_ready, alu_execute, op_a, op_b, funct3, op_sign,
           wb_valid, wb_rd, wb_data, illegal_instr
`ifdef ALU_ISSUE_FLAGS_EN
    , input wb_flags
`endif
  );

endinterface

// File: rtl/rv32i_alu_decode.sv
// Combinational OP / OP-IMM decoder: instruction word and source values to ALU controls,
// destination index and an illegal flag.
module rv32i_alu_decode
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [2:0]      funct3,
  output logic            op_sign,
  output logic [4:0]      rd,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       unused_rs1_idx;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  // Register indices are resolved upstream; only the values arrive here.
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    op_a    = rs1_data;
    op_b    = rs2_data;
    funct3  = instr[14:12];
    op_sign = 1'b0;
    rd      = instr[11:7];
    illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        op_sign = instr[30];
        illegal = !((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) &&
                     ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
      end
      OPC_OP_IMM: begin
        op_b = imm_i(instr);
        // Only SRAI may set op_sign; ADDI with imm[10] set must still add.
        op_sign = (funct3 == F3_SRL_SRA) ? instr[30] : 1'b0;
        if (funct3 == F3_SLL) begin
          illegal = (funct7 != F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
        end else begin
          illegal = 1'b0;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_alu_issue.sv
// Issue/writeback sequencer: IDLE accepts and decodes, EXEC drives the external ALU for one
// cycle, WB offers the result to the register file. Optional flag capture: ALU_ISSUE_FLAGS_EN.
module rv32i_alu_issue
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  rv32i_alu_issue_if.master bus
);

  logic [1:0]      state_q, state_d;
  alu_ctrl_t       ctrl_q, ctrl_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] dec_op_a;
  logic [XLEN-1:0] dec_op_b;
  logic [2:0]      dec_funct3;
  logic            dec_op_sign;
  logic [4:0]      dec_rd;
  logic            dec_illegal;

  rv32i_alu_decode #(.XLEN(XLEN)) u_decode (
    .instr    (bus.instr),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .op_a     (dec_op_a),
    .op_b     (dec_op_b),
    .funct3   (dec_funct3),
    .op_sign  (dec_op_sign),
    .rd       (dec_rd),
    .illegal  (dec_illegal)
  );

`ifdef ALU_ISSUE_FLAGS_EN
  logic [2:0] flags_q, flags_d;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = ^{bus.alu_zero, bus.alu_negative, bus.alu_overflow};
`endif

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    wb_data_d = wb_data_q;
    illegal_d = 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
    flags_d   = flags_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else begin
            ctrl_d.op_a    = dec_op_a;
            ctrl_d.op_b    = dec_op_b;
            ctrl_d.funct3  = dec_funct3;
            ctrl_d.op_sign = dec_op_sign;
            ctrl_d.rd      = dec_rd;
            state_d        = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // Writes to x0 are executed but dropped; wb_data keeps the last real write.
        if (ctrl_q.rd != 5'd0) begin
          wb_data_d = bus.alu_result;
`ifdef ALU_ISSUE_FLAGS_EN
          flags_d   = {bus.alu_zero, bus.alu_negative, bus.alu_overflow};
`endif
          state_d   = ST_WB;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      flags_q   <= 3'b000;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
`ifdef ALU_ISSUE_FLAGS_EN
      flags_q   <= flags_d;
`endif
    end
  end

  // Gated by reset_n so nothing upstream sees a ready while the block is held in reset.
  assign bus.instr_ready   = reset_n && (state_q == ST_IDLE);
  assign bus.alu_execute   = (state_q == ST_EXEC);
  assign bus.op_a          = ctrl_q.op_a;
  assign bus.op_b          = ctrl_q.op_b;
  assign bus.funct3        = ctrl_q.funct3;
  assign bus.op_sign       = ctrl_q.op_sign;
  assign bus.wb_valid      = (state_q == ST_WB);
  assign bus.wb_rd         = ctrl_q.rd;
  assign bus.wb_data       = wb_data_q;
  assign bus.illegal_instr = illegal_q;
`ifdef ALU_ISSUE_FLAGS_EN
  assign bus.wb_flags      = flags_q;
`endif

endmodule
